// File: rtl/stream_mux_rr.sv
// stream_mux_rr: N_CH-input round-robin streaming mux with one registered output stage.
// Each input and the output use a valid/ready handshake. Throughput is one beat per cycle.
// Optional packet mode is enabled by defining STREAM_MUX_PKT_LOCK_EN. It adds the in_last
// and out_last ports and holds the grant on one channel until that channel's last beat.

// Per-channel request qualification and ready gating
module stream_mux_rr_lane (
    input  logic valid,    // channel in_valid
    input  logic locked,   // arbiter is locked onto a packet
    input  logic owner,    // this channel owns the current lock
    input  logic granted,  // arbiter picked this channel
    input  logic open,     // output can accept a beat and reset is released
    output logic req,      // channel competes in this cycle's arbitration
    output logic ready     // in_ready for this channel
);
    // While locked, only the lock owner may request.
    assign req   = valid && (!locked || owner);
    assign ready = granted && open;
endmodule

module stream_mux_rr #(
    parameter  int N_CH = 4,
    parameter  int W    = 4,
    localparam int SW   = $clog2(N_CH)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [N_CH-1:0]     in_valid,
    input  logic [N_CH*W-1:0]   in_data,
    output logic [N_CH-1:0]     in_ready,
    output logic                out_valid,
    output logic [W-1:0]        out_data,
    output logic [SW-1:0]       out_sel,
    input  logic                out_ready
`ifdef STREAM_MUX_PKT_LOCK_EN
    ,
    input  logic [N_CH-1:0]     in_last,
    output logic                out_last
`endif
);

    // N_CH at the width of the rotated scan index. ptr + k stays below 2*N_CH <= 2^(SW+1).
    localparam logic [SW:0]   N_CH_W  = (SW+1)'(N_CH);
    localparam logic [SW-1:0] LAST_CH = SW'(N_CH - 1);

    // Output register, round-robin pointer and packet-lock state
    logic          out_valid_q, out_valid_d;
    logic [W-1:0]  out_data_q,  out_data_d;
    logic [SW-1:0] out_sel_q,   out_sel_d;
    logic [SW-1:0] ptr_q,       ptr_d;
    logic          lock_q,      lock_d;
    logic [SW-1:0] lock_ch_q,   lock_ch_d;
    logic          last_q,      last_d;

    // Arbitration signals
    logic            open;
    logic            xfer;
    logic            grant_found;
    logic [SW-1:0]   grant_idx;
    logic [SW:0]     scan_idx;
    logic [N_CH-1:0] req;
    logic [N_CH-1:0] granted;
    logic            beat_last;

    // The output is free when it is empty or draining this cycle. In reset, nothing is accepted.
    assign open = rst_n && (!out_valid_q || out_ready);

    // A beat moves only when a grant exists. The grant already implies in_valid and a free output.
    assign xfer = grant_found;

    // Per-channel request and ready logic
    for (genvar i = 0; i < N_CH; i++) begin : g_lane
        assign granted[i] = grant_found && (grant_idx == SW'(i));

        stream_mux_rr_lane u_lane (
            .valid   (in_valid[i]),
            .locked  (lock_q),
            .owner   (lock_ch_q == SW'(i)),
            .granted (granted[i]),
            .open    (open),
            .req     (req[i]),
            .ready   (in_ready[i])
        );
    end

    // Rotating priority scan: ptr, ptr+1, ..., wrapping. The first requester wins.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        scan_idx    = '0;
        for (int k = 0; k < N_CH; k++) begin
            scan_idx = {1'b0, ptr_q} + (SW+1)'(k);
            if (scan_idx >= N_CH_W) begin
                scan_idx = scan_idx - N_CH_W;
            end
            if (!grant_found && req[scan_idx[SW-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = scan_idx[SW-1:0];
            end
        end
        // No grant while the output is stalled or in reset
        if (!open) begin
            grant_found = 1'b0;
            grant_idx   = '0;
        end
    end

`ifdef STREAM_MUX_PKT_LOCK_EN
    assign beat_last = in_last[grant_idx];
`else
    // Without packet mode, every beat stands alone.
    assign beat_last = 1'b1;
`endif

    // Next state for the output register, pointer and lock
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_sel_d   = out_sel_q;
        ptr_d       = ptr_q;
        lock_d      = lock_q;
        lock_ch_d   = lock_ch_q;
        last_d      = last_q;
        if (xfer) begin
            // Load the new beat. This also covers a simultaneous drain and fill.
            out_valid_d = 1'b1;
            out_data_d  = in_data[int'(grant_idx)*W +: W];
            out_sel_d   = grant_idx;
            ptr_d       = (grant_idx == LAST_CH) ? '0 : grant_idx + 1'b1;
            last_d      = beat_last;
            // A non-last beat pins the arbiter to this channel until its last beat.
            lock_d      = !beat_last;
            lock_ch_d   = grant_idx;
        end else if (out_valid_q && out_ready) begin
            // Drain only. Data, select and last keep their values.
            out_valid_d = 1'b0;
        end
    end

    // State registers. Async reset drops any in-flight beat at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sel_q   <= '0;
            ptr_q       <= '0;
            lock_q      <= 1'b0;
            lock_ch_q   <= '0;
            last_q      <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sel_q   <= out_sel_d;
            ptr_q       <= ptr_d;
            lock_q      <= lock_d;
            lock_ch_q   <= lock_ch_d;
            last_q      <= last_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_sel   = out_sel_q;

`ifdef STREAM_MUX_PKT_LOCK_EN
    assign out_last  = last_q;
`endif

endmodule

// File: tb/tb_stream_mux_rr.sv
// Testbench for stream_mux_rr. Directed scenarios are followed by a randomized phase.
// Every cycle, outputs are compared with a behavioural model of the arbitration rules.
module tb_stream_mux_rr;
    localparam int N_CH = 4;
    localparam int W    = 4;
    localparam int SW   = 2;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [N_CH-1:0]   in_valid;
    logic [N_CH*W-1:0] in_data;
    logic [N_CH-1:0]   in_ready;
    logic              out_valid;
    logic [W-1:0]      out_data;
    logic [SW-1:0]     out_sel;
    logic              out_ready;
`ifdef STREAM_MUX_PKT_LOCK_EN
    logic [N_CH-1:0]   in_last;
    logic              out_last;
`endif

    stream_mux_rr #(.N_CH(N_CH), .W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_sel   (out_sel),
        .out_ready (out_ready)
`ifdef STREAM_MUX_PKT_LOCK_EN
        ,
        .in_last   (in_last),
        .out_last  (out_last)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Behavioural model: output contents, next-priority channel and packet owner
    bit m_valid;
    int m_data;
    int m_sel;
    int m_ptr;
    bit m_lock;
    int m_lock_ch;
    bit m_last;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_valid   = 1'b0;
        m_data    = 0;
        m_sel     = 0;
        m_ptr     = 0;
        m_lock    = 1'b0;
        m_lock_ch = 0;
        m_last    = 1'b0;
    endtask

    // Channel the rules say is granted now, or -1 if there is none
    function automatic int model_grant();
        int c;
        if (!rst_n) return -1;
        if (m_valid && !out_ready) return -1;
        for (int k = 0; k < N_CH; k++) begin
            c = (m_ptr + k) % N_CH;
            if ((!m_lock || c == m_lock_ch) && in_valid[c]) return c;
        end
        return -1;
    endfunction

    // Entered at a negedge after the inputs are driven. Checks, steps one clock, and returns at the next negedge.
    task automatic cycle();
        int g;
        int d;
        bit lst;
        logic [N_CH-1:0] exp_rdy;
        #1;
        g = model_grant();
        exp_rdy = '0;
        if (g >= 0) exp_rdy[g] = 1'b1;
        check("in_ready",  in_ready,  exp_rdy);
        check("out_valid", out_valid, m_valid);
        check("out_data",  out_data,  m_data);
        check("out_sel",   out_sel,   m_sel);
`ifdef STREAM_MUX_PKT_LOCK_EN
        check("out_last",  out_last,  m_last);
`endif
        d = 0;
        lst = 1'b1;
        if (g >= 0) begin
            d = int'(in_data[g*W +: W]);
`ifdef STREAM_MUX_PKT_LOCK_EN
            lst = in_last[g];
`endif
        end
        @(posedge clk);
        if (!rst_n) begin
            model_reset();
        end else if (g >= 0) begin
            m_valid = 1'b1;
            m_data  = d;
            m_sel   = g;
            m_ptr   = (g + 1) % N_CH;
`ifdef STREAM_MUX_PKT_LOCK_EN
            m_last    = lst;
            m_lock    = !lst;
            m_lock_ch = g;
`endif
        end else if (m_valid && out_ready) begin
            m_valid = 1'b0;
        end
        @(negedge clk);
    endtask

    initial begin
        model_reset();
        in_valid  = '1;
        in_data   = 16'h3210;
        out_ready = 1'b1;
`ifdef STREAM_MUX_PKT_LOCK_EN
        in_last   = '1;
`endif
        // Reset held with every channel valid: nothing is granted and the outputs are cleared.
        @(negedge clk);
        repeat (3) cycle();
        rst_n = 1'b1;
        // The first grant after release goes to ch0.
        #1 check("rst_first_grant", in_ready, 4'b0001);
        cycle();

        // Single source, ch2 carrying A
        in_valid = 4'b0100;
        in_data  = '0;
        in_data[8 +: 4] = 4'hA;
        cycle();
        check("t2_valid", out_valid, 1'b1);
        check("t2_data",  out_data,  4'hA);
        check("t2_sel",   out_sel,   2);
        repeat (4) cycle();

        // All channels valid: rotation with ch i carrying data i
        in_valid = '1;
        in_data  = 16'h3210;
        repeat (8) cycle();

        // Backpressure: beat 5 held for 5 stalled cycles
        in_data = 16'h5555;
        cycle();
        out_ready = 1'b0;
        repeat (5) begin
            #1;
            check("t4_hold_data", out_data, 4'h5);
            check("t4_no_ready",  in_ready, '0);
            cycle();
        end
        out_ready = 1'b1;
        repeat (4) cycle();

        // Reset asserted mid-stream while the output holds a beat
        out_ready = 1'b0;
        cycle();
        #2 rst_n = 1'b0;
        #1;
        check("t5_async_valid", out_valid, 1'b0);
        check("t5_async_ready", in_ready, '0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        in_valid  = '1;
        #1 check("t5_ptr_zero", in_ready, 4'b0001);
        cycle();

`ifdef STREAM_MUX_PKT_LOCK_EN
        // Packet lock: ch1 sends three beats while ch0 and ch2 are also valid.
        rst_n = 1'b0;
        #1 model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        in_data  = 16'h3210;
        in_valid = 4'b0010;
        in_last  = '0;
        cycle();
        check("t6_sel_b1", out_sel, 1);
        in_valid = 4'b0111;
        cycle();
        check("t6_sel_b2", out_sel, 1);
        in_last = 4'b0010;
        cycle();
        check("t6_sel_b3", out_sel, 1);
        check("t6_last_b3", out_last, 1'b1);
        in_last = '1;
        cycle();
        check("t6_sel_next", out_sel, 2);
`endif

        // Randomized traffic
        for (int n = 0; n < 1500; n++) begin
            in_valid  = N_CH'($urandom);
            in_data   = (N_CH*W)'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
`ifdef STREAM_MUX_PKT_LOCK_EN
            in_last   = N_CH'($urandom);
`endif
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
